// File: rtl/ef9345_bus_regfile.sv
`default_nettype none
// ============================================================================
// Module   : ef9345_bus_regfile
// Brief    : Synchronised multiplexed host-bus front end (Intel/Motorola),
//            direct-access register file and command start/busy/done handshake.
//            Optional status register at idx 0: define EF9345_STATUS_REG_EN.
// Revision : 1.0
// ============================================================================
module ef9345_bus_regfile #(
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       ADDR_W      = 8,
    parameter int unsigned       NREGS       = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 8'h20,
    parameter int unsigned       SYNC_STAGES = 2
) (
    input  logic                    clk_in,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       data_in,
    output logic [DATA_W-1:0]       data_out,
    output logic                    data_oe,
    input  logic                    as,
    input  logic                    ds,
    input  logic                    rw,
    input  logic                    cs_,
    output logic [NREGS*DATA_W-1:0] regs_out,
    output logic                    cmd_start,
    output logic                    cmd_busy,
    input  logic                    cmd_done
);

    localparam int unsigned IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_WRITE = 2'd2,
        S_READ  = 2'd3
    } state_t;

    // Control and data share one pipeline depth so they stay mutually aligned
    logic [3:0]        r_ctl_sync  [SYNC_STAGES];
    logic [DATA_W-1:0] r_data_sync [SYNC_STAGES];

    always_ff @(posedge clk_in) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_ctl_sync[i]  <= 4'b1111;
                r_data_sync[i] <= '0;
            end
        end else begin
            r_ctl_sync[0]  <= {as, ds, rw, cs_};
            r_data_sync[0] <= data_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_ctl_sync[i]  <= r_ctl_sync[i-1];
                r_data_sync[i] <= r_data_sync[i-1];
            end
        end
    end

    logic              w_as;
    logic              w_ds;
    logic              w_rw;
    logic              w_cs_n;
    logic [DATA_W-1:0] w_din;

    assign {w_as, w_ds, w_rw, w_cs_n} = r_ctl_sync[SYNC_STAGES-1];
    assign w_din                      = r_data_sync[SYNC_STAGES-1];

    state_t            r_state;
    logic              r_as_d;
    logic [ADDR_W-1:0] r_addr;
    logic              r_mode;
    logic              r_sel;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_data_out;
    logic              r_data_oe;
    logic              r_start;
    logic              r_busy;
    logic [DATA_W-1:0] r_regs [NREGS];

    logic              w_as_fall;
    logic              w_wr;
    logic              w_rd;
    logic              w_hit;
    logic [IDX_W-1:0]  w_idx;
    logic              w_exec;
    logic              w_commit;
    logic              w_commit_ok;
    logic              w_launch;
    logic [DATA_W-1:0] w_rdata;

    assign w_as_fall = r_as_d & ~w_as;

    // Mode 1 (Intel): rw acts as WR_, ds as RD_. Mode 0 (Motorola): ds qualifies rw.
    assign w_wr = r_mode ? ~w_rw : (~w_rw & w_ds);
    assign w_rd = r_mode ? ~w_ds : ( w_rw & w_ds);

    assign w_hit  = r_sel
                 && (r_addr[ADDR_W-1:4] == BASE_ADDR[ADDR_W-1:4])
                 && (32'(r_addr[2:0]) < NREGS);
    assign w_idx  = r_addr[IDX_W-1:0];
    assign w_exec = r_addr[3];

    // Busy is judged on its pre-cycle value, so a same-cycle cmd_done cannot rescue a commit
    assign w_commit    = (r_state == S_WRITE) && !w_as_fall && !w_wr;
    assign w_commit_ok = w_commit && !r_busy;
    assign w_launch    = w_commit_ok && w_exec;

`ifdef EF9345_STATUS_REG_EN
    logic r_overrun;
    logic w_discard;
    logic w_stat_clr;

    assign w_discard  = w_commit && r_busy;
    assign w_stat_clr = (r_state == S_READ) && r_data_oe && (w_as_fall || !w_rd)
                     && (r_addr[2:0] == 3'd0);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_discard) begin
            r_overrun <= 1'b1;
        end else if (w_stat_clr) begin
            r_overrun <= 1'b0;
        end
    end

    always_comb begin
        w_rdata = r_regs[w_idx];
        if (r_addr[2:0] == 3'd0) begin
            w_rdata = {r_busy, r_overrun, {(DATA_W-2){1'b0}}};
        end
    end
`else
    always_comb begin
        w_rdata = r_regs[w_idx];
    end
`endif

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_as_d     <= 1'b1;
            r_addr     <= '0;
            r_mode     <= 1'b0;
            r_sel      <= 1'b0;
            r_wdata    <= '0;
            r_data_out <= '0;
            r_data_oe  <= 1'b0;
            r_start    <= 1'b0;
            r_busy     <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_as_d  <= w_as;
            r_start <= w_launch;

            if (w_launch) begin
                r_busy <= 1'b1;
            end else if (cmd_done) begin
                r_busy <= 1'b0;
            end

            if (w_commit_ok) begin
                r_regs[w_idx] <= r_wdata;
            end

            // A new address strobe pre-empts whatever access is in flight
            if (w_as_fall) begin
                r_addr    <= w_din[ADDR_W-1:0];
                r_mode    <= w_ds;
                r_sel     <= ~w_cs_n;
                r_data_oe <= 1'b0;
                r_state   <= S_ADDR;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_IDLE;
                    end
                    S_ADDR: begin
                        if (!w_hit) begin
                            r_state <= S_IDLE;
                        end else if (w_wr) begin
                            r_wdata <= w_din;
                            r_state <= S_WRITE;
                        end else if (w_rd) begin
                            r_state <= S_READ;
                        end
                    end
                    S_WRITE: begin
                        if (w_wr) begin
                            r_wdata <= w_din;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_READ: begin
                        if (w_rd) begin
                            r_data_oe  <= 1'b1;
                            r_data_out <= w_rdata;
                        end else begin
                            r_data_oe <= 1'b0;
                            r_state   <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_regs_out
        assign regs_out[g*DATA_W +: DATA_W] = r_regs[g];
    end

    assign data_out  = r_data_out;
    assign data_oe   = r_data_oe;
    assign cmd_start = r_start;
    assign cmd_busy  = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_ef9345_bus_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_ef9345_bus_regfile
// Brief    : Directed plus randomized bus accesses against a register-file model.
// Revision : 1.0
// ============================================================================
module tb_ef9345_bus_regfile;

    localparam int DATA_W = 8;
    localparam int NREGS  = 8;
    localparam int SYNC   = 2;

    logic                    clk_in = 1'b0;
    logic                    reset  = 1'b1;
    logic [DATA_W-1:0]       data_in = '0;
    logic [DATA_W-1:0]       data_out;
    logic                    data_oe;
    logic                    as  = 1'b1;
    logic                    ds  = 1'b1;
    logic                    rw  = 1'b1;
    logic                    cs_ = 1'b1;
    logic [NREGS*DATA_W-1:0] regs_out;
    logic                    cmd_start;
    logic                    cmd_busy;
    logic                    cmd_done = 1'b0;

    always #5 clk_in = ~clk_in;

    ef9345_bus_regfile #(
        .DATA_W      (DATA_W),
        .ADDR_W      (8),
        .NREGS       (NREGS),
        .BASE_ADDR   (8'h20),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out),
        .data_oe   (data_oe),
        .as        (as),
        .ds        (ds),
        .rw        (rw),
        .cs_       (cs_),
        .regs_out  (regs_out),
        .cmd_start (cmd_start),
        .cmd_busy  (cmd_busy),
        .cmd_done  (cmd_done)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] m_regs [NREGS];
    bit         m_busy;
    bit         m_overrun;
    int         m_launches;
    int         start_cycles = 0;

    always @(negedge clk_in) begin
        if (cmd_start === 1'b1) start_cycles++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic m_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
        m_busy    = 1'b0;
        m_overrun = 1'b0;
    endtask

    function automatic logic [63:0] m_flat();
        logic [63:0] f;
        f = '0;
        for (int i = 0; i < NREGS; i++) f[i*8 +: 8] = m_regs[i];
        return f;
    endfunction

    function automatic logic [7:0] m_read(input int idx);
`ifdef EF9345_STATUS_REG_EN
        if (idx == 0) return {m_busy, m_overrun, 6'b000000};
`endif
        return m_regs[idx];
    endfunction

    task automatic pulse_done();
        cmd_done = 1'b1;
        tick(1);
        cmd_done = 1'b0;
        m_busy   = 1'b0;
        chk("done_clears_busy", cmd_busy, 1'b0);
    endtask

    // One complete bus cycle; intel selects the mode via ds level at the AS fall
    task automatic access(input bit intel, input bit wr, input bit csn,
                          input logic [7:0] addr, input logic [7:0] wdata);
        bit hit;
        bit exec;
        bit launch;
        int idx;
        hit    = !csn && (addr[7:4] == 4'h2);
        exec   = addr[3];
        idx    = int'(addr[2:0]);
        launch = 1'b0;

        as = 1'b1; ds = intel; rw = 1'b1; cs_ = csn; data_in = addr;
        tick(4);
        as = 1'b0;
        tick(4);
        cs_ = 1'b1;
        if (wr) begin
            data_in = wdata; rw = 1'b0;
            if (!intel) ds = 1'b1;
            tick(4);
            if (intel) rw = 1'b1; else ds = 1'b0;
            data_in = 8'($urandom);
            tick(SYNC);
            chk("wr_before_commit", regs_out, m_flat());
            tick(1);
            if (hit) begin
                if (!m_busy) begin
                    m_regs[idx] = wdata;
                    if (exec) begin
                        m_busy = 1'b1;
                        launch = 1'b1;
                        m_launches++;
                    end
                end else begin
                    m_overrun = 1'b1;
                end
            end
            chk("wr_commit", regs_out, m_flat());
            chk("wr_start", cmd_start, launch);
            chk("wr_busy", cmd_busy, m_busy);
            tick(1);
            chk("start_one_cycle", cmd_start, 1'b0);
            rw = 1'b1;
        end else begin
            if (intel) ds = 1'b0; else begin rw = 1'b1; ds = 1'b1; end
            tick(4);
            chk("rd_oe", data_oe, hit);
            if (hit) chk("rd_data", data_out, m_read(idx));
            if (intel) ds = 1'b1; else ds = 1'b0;
            tick(SYNC);
            chk("rd_oe_hold", data_oe, hit);
            tick(1);
            chk("rd_oe_fall", data_oe, 1'b0);
            if (hit && idx == 0) m_overrun = 1'b0;
        end
        as = 1'b1;
        tick(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit         intel;
        bit         wr;
        bit         csn;
        logic [7:0] addr;
        int         kind;

        m_reset();
        m_launches = 0;
        tick(3);
        reset = 1'b0;
        tick(2);
        chk("reset_regs", regs_out, 64'h0);
        chk("reset_oe", data_oe, 1'b0);
        chk("reset_dout", data_out, 8'h00);
        chk("reset_start", cmd_start, 1'b0);
        chk("reset_busy", cmd_busy, 1'b0);

        // Motorola write, then Intel read back
        access(1'b0, 1'b1, 1'b0, 8'h23, 8'hA5);
        chk("mot_write_r3", regs_out[31:24], 8'hA5);
        access(1'b1, 1'b0, 1'b0, 8'h23, 8'h00);
        access(1'b1, 1'b1, 1'b0, 8'h22, 8'h3C);

        // Misses
        access(1'b0, 1'b1, 1'b1, 8'h23, 8'h77);
        access(1'b1, 1'b0, 1'b0, 8'h33, 8'h00);
        access(1'b0, 1'b1, 1'b0, 8'h33, 8'h99);

        // Execute, discarded write while busy, status/R0 read, completion
        access(1'b0, 1'b1, 1'b0, 8'h28, 8'h42);
        chk("exec_r0", regs_out[7:0], 8'h42);
        access(1'b1, 1'b1, 1'b0, 8'h21, 8'h11);
        chk("busy_r1_unchanged", regs_out[15:8], 8'h00);
        access(1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
        pulse_done();
        access(1'b0, 1'b0, 1'b0, 8'h20, 8'h00);

        // Abort: new AS fall while a write is still strobing
        as = 1'b1; ds = 1'b0; rw = 1'b1; cs_ = 1'b0; data_in = 8'h22;
        tick(4);
        as = 1'b0;
        tick(4);
        data_in = 8'h5A; rw = 1'b0; ds = 1'b1;
        tick(4);
        as = 1'b1;
        tick(4);
        as = 1'b0; data_in = 8'h33;
        tick(4);
        ds = 1'b0; rw = 1'b1;
        tick(4);
        chk("abort_no_commit", regs_out, m_flat());
        as = 1'b1;
        tick(2);

        // Reset while a read is driving the bus
        ds = 1'b1; rw = 1'b1; cs_ = 1'b0; data_in = 8'h23;
        tick(4);
        as = 1'b0;
        tick(4);
        ds = 1'b0;
        tick(4);
        chk("pre_reset_oe", data_oe, 1'b1);
        reset = 1'b1;
        tick(1);
        m_reset();
        chk("reset_mid_oe", data_oe, 1'b0);
        chk("reset_mid_regs", regs_out, 64'h0);
        chk("reset_mid_busy", cmd_busy, 1'b0);
        as = 1'b1; ds = 1'b1; cs_ = 1'b1;
        tick(4);
        reset = 1'b0;
        tick(2);

        // Randomized accesses
        for (int n = 0; n < 60; n++) begin
            kind  = int'($urandom_range(0, 9));
            intel = 1'($urandom_range(0, 1));
            wr    = 1'($urandom_range(0, 1));
            addr  = {4'h2, 1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, NREGS-1))};
            csn   = 1'b0;
            if (kind == 0) csn = 1'b1;
            else if (kind == 1) addr[7:4] = 4'($urandom_range(3, 15));
            access(intel, wr, csn, addr, 8'($urandom));
            if ($urandom_range(0, 2) == 0) pulse_done();
        end

        chk("start_pulse_count", start_cycles, m_launches);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
